instr_fetch_buffer: RTL and testbench
=====================================

Name: instr_fetch_buffer

Overview:
- Fetch stage directly downstream of the 6-bit program counter (PC).
- Takes the counter's current address (range 1..61) and issues a read to the synchronous instruction memory.
- Pairs each returned word with the address it came from and queues the pair in a small FIFO that feeds decode.
- Provides backpressure (PCReady) so the counter can hold, and a Flush input for redirects.

Parameters:
ADDR_WIDTH, 6, PC/memory address width
DATA_WIDTH, 32, instruction word width
DEPTH, 4, FIFO entries; power of two, >= 2
MAX_ADDR, 61, highest legal PC; legal range is 1..MAX_ADDR
NOP_WORD, 0, word substituted for illegal-address fetches

Ports:
Clk  in  1  clock; all state updates on posedge
Reset  in  1  asynchronous, active-low; Reset=0 clears all state immediately
PC  in  ADDR_WIDTH  fetch address from the counter
PCValid  in  1  PC is valid this cycle
PCReady  out  1  block accepts PC this cycle; counter holds when low
MemAddr  out  ADDR_WIDTH  memory read address; combinationally equal to PC
MemRead  out  1  read strobe = PCValid & PCReady & ~Flush
MemData  in  DATA_WIDTH  read data, valid exactly one cycle after MemRead
Flush  in  1  synchronous; discards queued and in-flight fetches
Instr  out  DATA_WIDTH  head-of-FIFO instruction; 0 when empty
InstrPC  out  ADDR_WIDTH  address of Instr; 0 when empty
InstrValid  out  1  FIFO non-empty
InstrReady  in  1  decode consumes head when InstrValid & InstrReady
AddrErr  out  1  sticky: an illegal PC was accepted

Behaviour:
- Reset (asynchronous, Reset=0):
  - count=0, read/write pointers=0, inflight=0, inflight_pc=0, inflight_err=0, AddrErr=0.
  - Outputs: InstrValid=0, Instr=0, InstrPC=0.
- PCReady = (count + inflight) < DEPTH, computed from registered state only. There is no combinational path from InstrReady to PCReady. PCReady=0 while Flush=1.
- Accept at cycle t (PCValid & PCReady & ~Flush):
  - MemRead=1.
  - At the t edge: inflight<=1, inflight_pc<=PC, inflight_err<=(PC==0 || PC>MAX_ADDR).
  - No accept at t: inflight<=0.
- Cycle t+1, inflight=1 and Flush=0: push {data, inflight_pc} at the write pointer.
  - data = MemData, or NOP_WORD if inflight_err.
  - If inflight_err, AddrErr<=1. AddrErr is cleared only by Reset.
- Latency: PC accepted in cycle t gives InstrValid=1 in cycle t+2 when the FIFO was empty.
- Throughput: one instruction per cycle sustained when InstrReady=1 continuously.
- Pop (InstrValid & InstrReady): advance the read pointer at the edge. Push and pop in the same cycle leave count unchanged.
- Head stability: Instr and InstrPC stay stable while InstrValid=1 and InstrReady=0.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH. Overflow is impossible by construction because in-flight entries hold credit. A push when count==DEPTH is an assertion failure in simulation.
- Flush=1 in cycle f, at the f edge:
  - count<=0, pointers<=0, inflight<=0.
  - MemData arriving in cycle f is discarded.
  - Pop is ignored in cycle f; InstrValid is still visible in f.
  - Cycle f+1 resumes normal operation; PC may be accepted in f+1.
- Flush overrides simultaneous accept, push and pop. AddrErr is unaffected by Flush.
- Reset asserted mid-operation: all state clears immediately. The memory response in the cycle after Reset deasserts is ignored because inflight=0.
- The block never reorders: FIFO order equals PC accept order.

Test Plan:
- Reset then stream: PC=1..5 with PCValid=1, InstrReady=1, MemData=0xA000_0000+addr → InstrValid first rises 2 cycles after the PC=1 accept; Instr/InstrPC pairs appear in order (0xA000_0001,1)..(0xA000_0005,5), one per cycle; PCReady stays 1.
- Backpressure: InstrReady=0, stream PC=10,11,… → exactly 4 accepts, then PCReady=0 and MemRead=0; raising InstrReady drains PCs 10..13 in order; PCReady returns to 1 the cycle after the first pop.
- Hold: InstrReady=0 with head PC=7 → Instr/InstrPC unchanged for 5 cycles; a simultaneous push and pop at count=2 keeps count at 2.
- Flush: accept PC=20 in cycle t, assert Flush in t+1 with 2 entries queued → InstrValid=0 and PCReady=1 in t+2; PC=20's data is never presented; PC=40 accepted in t+2 appears as the next instruction.
- Illegal address: accept PC=0 and then PC=62 with MemData=0xDEAD_BEEF → both entries present Instr=0x0000_0000; AddrErr=1 from the cycle after the first push and stays set through a Flush.
- Async reset mid-stream: drop Reset between edges with 3 entries queued and one in flight → InstrValid=0 and AddrErr=0 immediately; no stale instruction appears after release.

Source files
------------

// File: rtl/instr_fetch_buffer_if.sv
// Fetch-buffer bus: PC handshake, synchronous memory port and decode-side FIFO port.
interface instr_fetch_buffer_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] PC;
  logic                  PCValid;
  logic                  PCReady;
  logic [ADDR_WIDTH-1:0] MemAddr;
  logic                  MemRead;
  logic [DATA_WIDTH-1:0] MemData;
  logic                  Flush;
  logic [DATA_WIDTH-1:0] Instr;
  logic [ADDR_WIDTH-1:0] InstrPC;
  logic                  InstrValid;
  logic                  InstrReady;
  logic                  AddrErr;

  // Environment side: program counter, instruction memory, decode, redirect.
  modport master (
    output PC, PCValid, MemData, Flush, InstrReady,
    input  PCReady, MemAddr, MemRead, Instr, InstrPC, InstrValid, AddrErr
  );

  // Fetch buffer side.
  modport slave (
    input  PC, PCValid, MemData, Flush, InstrReady,
    output PCReady, MemAddr, MemRead, Instr, InstrPC, InstrValid, AddrErr
  );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: issues PC reads to a synchronous memory, pairs each
// returned word with its address and queues the pair in a small FIFO for decode.
// An issued read holds a FIFO credit so the queue can never overflow.
module instr_fetch_buffer #(
  parameter int unsigned           ADDR_WIDTH = 6,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter int unsigned           MAX_ADDR   = 61,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  instr_fetch_buffer_if.slave   bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W:0]          count;
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic                    inflight;
  logic [ADDR_WIDTH-1:0]   inflight_pc;
  logic                    inflight_err;
  logic                    addr_err;

  logic [DATA_WIDTH-1:0]   data_q [DEPTH];
  logic [ADDR_WIDTH-1:0]   pc_q   [DEPTH];

  logic [PTR_W+1:0]        credit;
  logic                    accept;
  logic                    push;
  logic                    pop;
  logic                    pc_illegal;
  logic                    not_empty;
  logic [DATA_WIDTH-1:0]   push_data;

  // Handshake and credit: readiness depends only on registered occupancy plus Flush.
  always_comb begin
    credit      = {1'b0, count} + {{(PTR_W+1){1'b0}}, inflight};
    bus.PCReady = (credit < (PTR_W+2)'(DEPTH)) && !bus.Flush;
    accept      = bus.PCValid && bus.PCReady;
    bus.MemAddr = bus.PC;
    bus.MemRead = accept;
    pc_illegal  = (bus.PC == '0) || (32'(bus.PC) > MAX_ADDR);
    not_empty   = (count != '0);
    push        = inflight && !bus.Flush;
    pop         = not_empty && bus.InstrReady && !bus.Flush;
    push_data   = inflight_err ? NOP_WORD : bus.MemData;
  end

  // Head-of-queue presentation, forced to zero when empty.
  always_comb begin
    bus.InstrValid = not_empty;
    bus.Instr      = not_empty ? data_q[rd_ptr] : '0;
    bus.InstrPC    = not_empty ? pc_q[rd_ptr]   : '0;
    bus.AddrErr    = addr_err;
  end

  // Control state: pointers, occupancy, in-flight read tracking, sticky error.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      inflight     <= 1'b0;
      inflight_pc  <= '0;
      inflight_err <= 1'b0;
      addr_err     <= 1'b0;
    end else if (bus.Flush) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= accept;
      if (accept) begin
        inflight_pc  <= bus.PC;
        inflight_err <= pc_illegal;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (inflight_err) addr_err <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W+1)'(1);
      else if (pop && !push) count <= count - (PTR_W+1)'(1);
    end
  end

  // FIFO storage; written only on a non-flushed push, so no reset is needed.
  always_ff @(posedge Clk) begin
    if (push) begin
      data_q[wr_ptr] <= push_data;
      pc_q[wr_ptr]   <= inflight_pc;
    end
  end

  a_no_overflow: assert property (@(posedge Clk) disable iff (!Reset)
    !(push && (count == (PTR_W+1)'(DEPTH))));

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Scoreboard bench for instr_fetch_buffer: directed stimulus pushes expected
// {instr, pc} pairs; a negedge monitor pops and compares on every consumed head.
module tb_instr_fetch_buffer;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;

  logic Clk;
  logic Reset;

  instr_fetch_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  instr_fetch_buffer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (4),
    .MAX_ADDR   (61),
    .NOP_WORD   (32'h0000_0000)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [AW-1:0] pc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Instruction memory contents: illegal addresses hold a poison word.
  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    if (a == 6'd0 || a > 6'd61) return 32'hDEAD_BEEF;
    return 32'hA000_0000 + 32'(a);
  endfunction

  // Synchronous read memory: data valid the cycle after MemRead.
  always @(posedge Clk) begin
    if (bus.MemRead) bus.MemData <= memf(bus.MemAddr);
  end

  // Monitor: every consumed head must match the next expected pair.
  always @(negedge Clk) begin
    if (Reset && bus.InstrValid && bus.InstrReady && !bus.Flush) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_instr: got instr=%h pc=%0d, required nothing", bus.Instr, bus.InstrPC);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.Instr !== mon_e.instr || bus.InstrPC !== mon_e.pc) begin
          miscompares++;
          $display("FAIL instr_pair: got instr=%h pc=%0d, required instr=%h pc=%0d",
                   bus.Instr, bus.InstrPC, mon_e.instr, mon_e.pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic neg();
    @(negedge Clk);
  endtask

  task automatic chk1(input string name, input logic act, input logic expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %b, required %b", name, act, expv);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, expv);
    end
  endtask

  task automatic expect_push(input logic [AW-1:0] pc, input logic [DW-1:0] d);
    exp_t e;
    e.instr = d;
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || bus.InstrValid) && n < 20) begin
      step();
      n++;
    end
    vectors++;
    if (exp_q.size() != 0 || bus.InstrValid) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d pending valid=%b, required 0 pending valid=0",
               name, exp_q.size(), bus.InstrValid);
    end
  endtask

  initial begin
    Reset          = 1'b0;
    bus.PC         = '0;
    bus.PCValid    = 1'b0;
    bus.Flush      = 1'b0;
    bus.InstrReady = 1'b0;
    step();
    step();

    // Reset state
    neg();
    chk1 ("rst_valid",   bus.InstrValid, 1'b0);
    chk32("rst_instr",   bus.Instr,      32'h0);
    chk32("rst_instrpc", 32'(bus.InstrPC), 32'h0);
    chk1 ("rst_addrerr", bus.AddrErr,    1'b0);
    chk1 ("rst_pcready", bus.PCReady,    1'b1);
    step();
    Reset = 1'b1;
    step();

    // Stream PC=1..5: first valid two cycles after the PC=1 accept
    bus.InstrReady = 1'b1;
    bus.PCValid    = 1'b1;
    for (int a = 1; a <= 5; a++) begin
      bus.PC = AW'(a);
      expect_push(AW'(a), 32'hA000_0000 + 32'(a));
      neg();
      chk1("stream_pcready", bus.PCReady,    1'b1);
      chk1("stream_valid",   bus.InstrValid, (a >= 3));
      step();
    end
    bus.PCValid = 1'b0;
    drain("stream");

    // Backpressure: four credits, then hold
    bus.InstrReady = 1'b0;
    bus.PCValid    = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.PC = AW'(10 + ((k < 4) ? k : 4));
      if (k < 4) expect_push(AW'(10 + k), 32'hA000_0000 + 32'(10 + k));
      neg();
      chk1("bp_pcready", bus.PCReady, (k < 4));
      chk1("bp_memread", bus.MemRead, (k < 4));
      step();
    end
    bus.PCValid    = 1'b0;
    bus.InstrReady = 1'b1;
    neg();
    chk1("bp_pcready_full", bus.PCReady, 1'b0);
    step();
    neg();
    chk1("bp_pcready_after_pop", bus.PCReady, 1'b1);
    step();
    drain("bp");

    // Hold head stable, then push and pop together at count 2
    bus.InstrReady = 1'b0;
    bus.PCValid    = 1'b1;
    bus.PC         = AW'(7);
    expect_push(AW'(7), 32'hA000_0007);
    step();
    bus.PC = AW'(8);
    expect_push(AW'(8), 32'hA000_0008);
    step();
    bus.PCValid = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      neg();
      chk32("hold_instr", bus.Instr, 32'hA000_0007);
      chk32("hold_pc",    32'(bus.InstrPC), 32'd7);
      chk1 ("hold_valid", bus.InstrValid, 1'b1);
      step();
    end
    bus.PC      = AW'(9);
    bus.PCValid = 1'b1;
    expect_push(AW'(9), 32'hA000_0009);
    neg();
    chk1("pp_accept9", bus.MemRead, 1'b1);
    step();
    bus.PCValid    = 1'b0;
    bus.InstrReady = 1'b1;
    step();
    bus.InstrReady = 1'b0;
    neg();
    chk32("pp_count", 32'(dut.count), 32'd2);
    chk32("pp_head",  32'(bus.InstrPC), 32'd8);
    step();
    bus.InstrReady = 1'b1;
    drain("pushpop");

    // Flush with two queued and PC=20 in flight
    bus.InstrReady = 1'b0;
    bus.PCValid    = 1'b1;
    bus.PC         = AW'(18);
    step();
    bus.PC = AW'(19);
    step();
    bus.PC = AW'(20);
    neg();
    chk1("fl_accept20", bus.MemRead, 1'b1);
    step();
    bus.Flush      = 1'b1;
    bus.PC         = AW'(21);
    bus.InstrReady = 1'b1;
    neg();
    chk1("fl_valid_in_f",   bus.InstrValid, 1'b1);
    chk1("fl_pcready_in_f", bus.PCReady,    1'b0);
    chk1("fl_memread_in_f", bus.MemRead,    1'b0);
    step();
    bus.Flush = 1'b0;
    bus.PC    = AW'(40);
    expect_push(AW'(40), 32'hA000_0028);
    neg();
    chk1("fl_valid_after",   bus.InstrValid, 1'b0);
    chk1("fl_pcready_after", bus.PCReady,    1'b1);
    chk1("fl_accept40",      bus.MemRead,    1'b1);
    step();
    bus.PCValid = 1'b0;
    drain("flush");

    // Illegal addresses fetch NOP and set sticky AddrErr
    bus.InstrReady = 1'b1;
    bus.PCValid    = 1'b1;
    bus.PC         = AW'(0);
    expect_push(AW'(0), 32'h0000_0000);
    neg();
    chk1("ill_accept0", bus.MemRead, 1'b1);
    step();
    bus.PC = AW'(62);
    expect_push(AW'(62), 32'h0000_0000);
    neg();
    chk1("ill_adderr_before", bus.AddrErr, 1'b0);
    step();
    bus.PCValid = 1'b0;
    neg();
    chk1("ill_adderr_set", bus.AddrErr, 1'b1);
    step();
    drain("illegal");
    bus.Flush = 1'b1;
    step();
    bus.Flush = 1'b0;
    neg();
    chk1("ill_adderr_after_flush", bus.AddrErr, 1'b1);
    step();

    // Asynchronous reset with three queued and one in flight
    bus.InstrReady = 1'b0;
    bus.PCValid    = 1'b1;
    for (int a = 30; a <= 33; a++) begin
      bus.PC = AW'(a);
      step();
    end
    bus.PCValid = 1'b0;
    neg();
    chk1("ar_valid_before", bus.InstrValid, 1'b1);
    #2;
    Reset = 1'b0;
    #1;
    chk1 ("ar_valid_now",   bus.InstrValid, 1'b0);
    chk1 ("ar_adderr_now",  bus.AddrErr,    1'b0);
    chk32("ar_instr_now",   bus.Instr,      32'h0);
    chk32("ar_instrpc_now", 32'(bus.InstrPC), 32'h0);
    step();
    Reset          = 1'b1;
    bus.InstrReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      neg();
      chk1("ar_no_stale", bus.InstrValid, 1'b0);
      step();
    end

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL final_queue: got %0d pending, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
